multicycle_maindec: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It is the successor to the single-cycle main decoder and sequences each instruction over 3–5 cycles.
- Moore outputs drive the PC, IR, register-file and memory enables and the datapath muxes.
- It adds BNE, ORI and a memory-ready stall, and flags illegal opcodes.
- It sits in the controller beside aludec, which consumes aluop.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mcd_outdec.sv | 67 ++++++
 rtl/multicycle_maindec.sv | 99 +++++++++
 tb/tb_multicycle_maindec.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU op codes,
// FSM state encoding and the packed control word produced per state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12,
    ORIWB   = 4'd13,
    BNEEX   = 4'd14
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mcd_outdec.sv
// Pure state -> control word table for the multicycle main decoder.
// FETCH reports pcwrite/irwrite as 1; the top gates them with mem_ready.
module mcd_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.pcwrite = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
      end
      DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX, BNEEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsrc    = 2'b01;
        ctrl.branch   = (state == BEQEX);
        ctrl.branchne = (state == BNEEX);
      end
      ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.immzext = 1'b1;
        ctrl.aluop   = ALUOP_OR;
      end
      ADDIWB, ORIWB: ctrl.regwrite = 1'b1;
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic, mem_ready gating in FETCH and illegal-opcode flag.
module multicycle_maindec
  import mips_ctrl_pkg::*;
#(
  parameter bit          EXT_EN = 1'b1,
  parameter int unsigned STW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [5:0]     op,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           branch,
  output logic           branchne,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic           immzext,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           illegal,
  output logic [STW-1:0] state
);

  state_t cur, nxt;
  ctrl_t  cw;
  logic   dec_illegal;
  logic   fetch_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt         = FETCH;
    dec_illegal = 1'b0;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          OP_BNE: begin
            if (EXT_EN) nxt = BNEEX;
            else        dec_illegal = 1'b1;
          end
          OP_ORI: begin
            if (EXT_EN) nxt = ORIEX;
            else        dec_illegal = 1'b1;
          end
          default:      dec_illegal = 1'b1;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      ORIEX:   nxt = ORIWB;
      default: nxt = FETCH;
    endcase
  end

  mcd_outdec u_outdec (
    .state (cur),
    .ctrl  (cw)
  );

  // Reset holds the FSM in FETCH, so FETCH's ready-gated enables must also see reset.
  assign fetch_go = mem_ready & ~reset;

  assign pcwrite  = (cur == FETCH) ? (cw.pcwrite & fetch_go) : cw.pcwrite;
  assign irwrite  = (cur == FETCH) ? (cw.irwrite & fetch_go) : cw.irwrite;
  assign branch   = cw.branch;
  assign branchne = cw.branchne;
  assign memwrite = cw.memwrite;
  assign regwrite = cw.regwrite;
  assign iord     = cw.iord;
  assign memtoreg = cw.memtoreg;
  assign regdst   = cw.regdst;
  assign alusrca  = cw.alusrca;
  assign alusrcb  = cw.alusrcb;
  assign immzext  = cw.immzext;
  assign pcsrc    = cw.pcsrc;
  assign aluop    = cw.aluop;
  assign illegal  = dec_illegal & ~reset;
  assign state    = STW'(cur);

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: cycle table, hand-written
// stall/reset/illegal sequences, and random stimulus against a queue model.
module tb_multicycle_maindec;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7, S_BEQEX = 8, S_ADDIEX = 9;
  localparam int S_ADDIWB = 10, S_JEX = 11, S_ORIEX = 12, S_ORIWB = 13, S_BNEEX = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with extensions enabled
  logic rst1, mr1;
  logic [5:0] op1;
  logic pcwrite1, branch1, branchne1, irwrite1, memwrite1, regwrite1, iord1, memtoreg1;
  logic regdst1, alusrca1, immzext1, illegal1;
  logic [1:0] alusrcb1, pcsrc1, aluop1;
  logic [3:0] state1;
  logic [17:0] act1;

  // DUT with extensions disabled and a wider debug port
  logic rst0, mr0;
  logic [5:0] op0;
  logic pcwrite0, branch0, branchne0, irwrite0, memwrite0, regwrite0, iord0, memtoreg0;
  logic regdst0, alusrca0, immzext0, illegal0;
  logic [1:0] alusrcb0, pcsrc0, aluop0;
  logic [4:0] state0;

  multicycle_maindec #(.EXT_EN(1'b1), .STW(4)) dut1 (
    .clk(clk), .reset(rst1), .op(op1), .mem_ready(mr1),
    .pcwrite(pcwrite1), .branch(branch1), .branchne(branchne1), .irwrite(irwrite1),
    .memwrite(memwrite1), .regwrite(regwrite1), .iord(iord1), .memtoreg(memtoreg1),
    .regdst(regdst1), .alusrca(alusrca1), .alusrcb(alusrcb1), .immzext(immzext1),
    .pcsrc(pcsrc1), .aluop(aluop1), .illegal(illegal1), .state(state1)
  );

  multicycle_maindec #(.EXT_EN(1'b0), .STW(5)) dut0 (
    .clk(clk), .reset(rst0), .op(op0), .mem_ready(mr0),
    .pcwrite(pcwrite0), .branch(branch0), .branchne(branchne0), .irwrite(irwrite0),
    .memwrite(memwrite0), .regwrite(regwrite0), .iord(iord0), .memtoreg(memtoreg0),
    .regdst(regdst0), .alusrca(alusrca0), .alusrcb(alusrcb0), .immzext(immzext0),
    .pcsrc(pcsrc0), .aluop(aluop0), .illegal(illegal0), .state(state0)
  );

  assign act1 = {pcwrite1, branch1, branchne1, irwrite1, memwrite1, regwrite1,
                 iord1, memtoreg1, regdst1, alusrca1, alusrcb1, immzext1,
                 pcsrc1, aluop1, illegal1};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected output vector for a state, straight from the per-state output list
  function automatic logic [17:0] spec_out(input int st, input bit mr, input bit rst,
                                           input logic [5:0] op, input bit ext);
    logic pw, br, bn, ir, mw, rw, io, mt, rd, sa, iz, il;
    logic [1:0] sb, ps, ao;
    {pw, br, bn, ir, mw, rw, io, mt, rd, sa, iz, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      S_FETCH:   begin sb = 2'b01; pw = mr & !rst; ir = mr & !rst; end
      S_DECODE:  begin
        sb = 2'b11;
        il = !(op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J ||
               (ext && (op == BNE || op == ORI))) && !rst;
      end
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin mt = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_RTYPEEX: begin sa = 1; ao = 2'b10; end
      S_RTYPEWB: begin rd = 1; rw = 1; end
      S_BEQEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      S_BNEEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_ORIEX:   begin sa = 1; sb = 2'b10; iz = 1; ao = 2'b11; end
      S_ADDIWB, S_ORIWB: rw = 1;
      S_JEX:     begin ps = 2'b10; pw = 1; end
      default:   ;
    endcase
    return {pw, br, bn, ir, mw, rw, io, mt, rd, sa, sb, iz, ps, ao, il};
  endfunction

  // Reference model: current step plus a queue of the instruction's remaining steps
  int mcur;
  int pend[$];

  task automatic model_step(input logic [5:0] op, input bit mr);
    bit stay;
    stay = (mcur == S_FETCH || mcur == S_MEMRD || mcur == S_MEMWR) && !mr;
    if (!stay) begin
      if (mcur == S_FETCH) pend.push_back(S_DECODE);
      else if (mcur == S_DECODE) begin
        pend.delete();
        if (op == LW || op == SW) pend.push_back(S_MEMADR);
        else if (op == RT)   begin pend.push_back(S_RTYPEEX); pend.push_back(S_RTYPEWB); end
        else if (op == BEQ)  pend.push_back(S_BEQEX);
        else if (op == ADDI) begin pend.push_back(S_ADDIEX); pend.push_back(S_ADDIWB); end
        else if (op == J)    pend.push_back(S_JEX);
        else if (op == BNE)  pend.push_back(S_BNEEX);
        else if (op == ORI)  begin pend.push_back(S_ORIEX); pend.push_back(S_ORIWB); end
      end else if (mcur == S_MEMADR) begin
        if (op == LW) begin pend.push_back(S_MEMRD); pend.push_back(S_MEMWB); end
        else pend.push_back(S_MEMWR);
      end
      mcur = (pend.size() > 0) ? pend.pop_front() : S_FETCH;
    end
  endtask

  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         mr;
    int         st;
  } row_t;
  row_t tbl[$];

  function automatic void add(input bit r, input logic [5:0] o, input bit m, input int s);
    row_t t;
    t.rst = r; t.op = o; t.mr = m; t.st = s;
    tbl.push_back(t);
  endfunction

  int fw, ww, cyc, pwc, mwc;
  bit left, done;
  logic [5:0] ill_ops[3];

  initial begin
    rst1 = 1'b1; mr1 = 1'b1; op1 = LW;
    rst0 = 1'b1; mr0 = 1'b1; op0 = RT;

    // One row per cycle: {reset, op, mem_ready, expected state}
    add(1, LW, 1, S_FETCH);
    add(0, LW, 1, S_FETCH);  add(0, LW, 1, S_DECODE); add(0, LW, 1, S_MEMADR);
    add(0, LW, 0, S_MEMRD);  add(0, LW, 1, S_MEMRD);  add(0, LW, 1, S_MEMWB);
    add(0, BEQ, 1, S_FETCH); add(0, BEQ, 1, S_DECODE); add(0, BEQ, 1, S_BEQEX);
    add(0, BNE, 1, S_FETCH); add(0, BNE, 1, S_DECODE); add(0, BNE, 1, S_BNEEX);
    add(0, ORI, 1, S_FETCH); add(0, ORI, 1, S_DECODE); add(0, ORI, 1, S_ORIEX);
    add(0, ORI, 1, S_ORIWB);
    add(0, BAD, 1, S_FETCH); add(0, BAD, 1, S_DECODE);
    add(0, RT, 1, S_FETCH);  add(0, RT, 1, S_DECODE);  add(0, LW, 1, S_RTYPEEX);
    add(0, LW, 1, S_RTYPEWB);
    add(0, ADDI, 1, S_FETCH); add(0, ADDI, 1, S_DECODE); add(0, ADDI, 1, S_ADDIEX);
    add(0, ADDI, 1, S_ADDIWB);
    add(0, J, 1, S_FETCH);   add(0, J, 1, S_DECODE);   add(0, J, 1, S_JEX);
    add(0, LW, 0, S_FETCH);  add(0, SW, 1, S_FETCH);   add(0, SW, 1, S_DECODE);
    add(0, SW, 1, S_MEMADR); add(0, SW, 1, S_MEMWR);   add(0, SW, 1, S_FETCH);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst1 = tbl[i].rst; op1 = tbl[i].op; mr1 = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_state", i), 32'(state1), tbl[i].st);
      chk($sformatf("tbl%0d_outs", i), 32'(act1), 32'(spec_out(tbl[i].st, tbl[i].mr, tbl[i].rst, tbl[i].op, 1'b1)));
    end

    // SW with 3 FETCH wait cycles and 2 MEMWR wait cycles
    @(negedge clk); rst1 = 1'b1; op1 = SW; mr1 = 1'b0;
    @(negedge clk); rst1 = 1'b0;
    fw = 0; ww = 0; cyc = 0; pwc = 0; mwc = 0; left = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (state1 == 4'd0 && left) done = 1;
      else begin
        if (state1 == 4'd0 && fw < 3) begin mr1 = 1'b0; fw++; end
        else if (state1 == 4'd5 && ww < 2) begin mr1 = 1'b0; ww++; end
        else mr1 = 1'b1;
        #1;
        cyc++; pwc += int'(pcwrite1); mwc += int'(memwrite1);
        if (state1 != 4'd0) left = 1;
        @(negedge clk);
      end
    end
    chk("sw_completes", 32'(done), 1);
    chk("sw_cycles", cyc, 9);
    chk("sw_pcwrite_pulses", pwc, 1);
    chk("sw_memwrite_cycles", mwc, 3);

    // Reset asserted mid-MEMWR with memory not ready
    mr1 = 1'b1; op1 = SW;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mr1 = 1'b0; #1;
    chk("memwr_state", 32'(state1), S_MEMWR);
    chk("memwr_memwrite", 32'(memwrite1), 1);
    #2 rst1 = 1'b1; #1;
    chk("async_rst_state", 32'(state1), S_FETCH);
    chk("async_rst_memwrite", 32'(memwrite1), 0);
    mr1 = 1'b1; #1;
    chk("rst_gates_pc_ir", 32'({pcwrite1, irwrite1}), 0);
    @(negedge clk); rst1 = 1'b0; #1;
    chk("release_pc_ir", 32'({pcwrite1, irwrite1}), 3);
    chk("release_state", 32'(state1), S_FETCH);

    // EXT_EN=0: BNE and ORI decode exactly like an undefined opcode
    @(negedge clk); rst0 = 1'b0; mr0 = 1'b1;
    ill_ops[0] = BNE; ill_ops[1] = BAD; ill_ops[2] = ORI;
    foreach (ill_ops[i]) begin
      op0 = ill_ops[i]; #1;
      chk($sformatf("ill%0d_fetch", i), 32'(state0), S_FETCH);
      @(negedge clk); #1;
      chk($sformatf("ill%0d_decode", i), 32'(state0), S_DECODE);
      chk($sformatf("ill%0d_illegal", i), 32'(illegal0), 1);
      chk($sformatf("ill%0d_enables", i),
          32'({pcwrite0, branch0, branchne0, irwrite0, memwrite0, regwrite0}), 0);
      @(negedge clk); #1;
      chk($sformatf("ill%0d_back", i), 32'(state0), S_FETCH);
      chk($sformatf("ill%0d_pulse", i), 32'(illegal0), 0);
    end
    op0 = LW;
    @(negedge clk); #1;
    chk("ext0_lw_decode", 32'({illegal0, state0}), S_DECODE);
    @(negedge clk); #1;
    chk("ext0_lw_memadr", 32'(state0), S_MEMADR);

    // Random stimulus against the reference model
    @(negedge clk); rst1 = 1'b1; #1;
    mcur = S_FETCH; pend.delete();
    @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst1 = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0: op1 = LW;   1: op1 = SW;  2: op1 = RT;   3: op1 = BEQ;
        4: op1 = BNE;  5: op1 = ADDI; 6: op1 = ORI; 7: op1 = J;
        default: op1 = 6'($urandom);
      endcase
      mr1 = ($urandom_range(0, 3) != 0);
      if (rst1) begin mcur = S_FETCH; pend.delete(); end
      #1;
      chk("rand_state", 32'(state1), mcur);
      chk("rand_outs", 32'(act1), 32'(spec_out(mcur, mr1, rst1, op1, 1'b1)));
      @(posedge clk);
      if (!rst1) model_step(op1, mr1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
